// File: rtl/trng_seq_ctrl.sv
// Entropy source sequencer: holds the source in reset, warms it up, then decimates and health-checks captures.
// Captured words appear on o_data one cycle after capture; a capture arriving while a word is stalled is dropped and flagged on o_overrun.
module trng_seq_ctrl #(
  parameter int RNG_WIDTH     = 32,
  parameter int WARMUP_CYCLES = 16,
  parameter int SAMPLE_DIV    = 4,
  parameter int REP_LIMIT     = 3,
  parameter int CNT_W         = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_clear_fail,
  output logic                 o_src_reset,
  output logic                 o_src_en,
  input  logic [RNG_WIDTH-1:0] i_src_rnd,
  output logic [RNG_WIDTH-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_fail,
  output logic                 o_overrun
);

  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [REP_W-1:0] REP_LIM   = REP_W'(REP_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_FAIL   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]     cnt;
  logic [RNG_WIDTH-1:0] prev;
  logic                 prev_vld;
  logic [REP_W-1:0]     rep_cnt;
  logic [REP_W-1:0]     rep_nxt;
  logic                 capture;
  logic                 health_fail;

  logic                 src_reset_nxt;
  logic                 src_en_nxt;
  logic                 busy_nxt;
  logic                 fail_nxt;
  logic                 valid_nxt;
  logic [RNG_WIDTH-1:0] data_nxt;
  logic                 overrun_nxt;

  // A stop request pre-empts a capture landing in the same cycle.
  assign capture     = (state == S_RUN) && (cnt == DIV_LAST) && !i_stop;
  assign rep_nxt     = (prev_vld && (i_src_rnd == prev)) ? rep_cnt + 1'b1 : REP_W'(1);
  assign health_fail = capture && (rep_nxt >= REP_LIM);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_start && !i_stop) state_nxt = S_WARMUP;
      end
      S_WARMUP: begin
        if (i_stop)                 state_nxt = S_IDLE;
        else if (cnt == WARM_LAST)  state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_stop)            state_nxt = S_IDLE;
        else if (health_fail)  state_nxt = S_FAIL;
      end
      S_FAIL: begin
        if (i_clear_fail) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    src_reset_nxt = 1'b1;
    src_en_nxt    = 1'b0;
    busy_nxt      = 1'b0;
    fail_nxt      = 1'b0;
    case (state_nxt)
      S_WARMUP, S_RUN: begin
        src_reset_nxt = 1'b0;
        src_en_nxt    = 1'b1;
        busy_nxt      = 1'b1;
      end
      S_FAIL:  fail_nxt = 1'b1;
      default: ;
    endcase

    valid_nxt   = o_valid && !i_ready;
    data_nxt    = o_data;
    overrun_nxt = 1'b0;
    if (capture && !health_fail) begin
      if (!o_valid || i_ready) begin
        data_nxt  = i_src_rnd;
        valid_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end
    // Leaving the active states discards any word still waiting for the consumer.
    if (state_nxt != S_WARMUP && state_nxt != S_RUN) valid_nxt = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_src_reset <= 1'b1;
      o_src_en    <= 1'b0;
      o_busy      <= 1'b0;
      o_fail      <= 1'b0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_overrun   <= 1'b0;
    end else begin
      o_src_reset <= src_reset_nxt;
      o_src_en    <= src_en_nxt;
      o_busy      <= busy_nxt;
      o_fail      <= fail_nxt;
      o_valid     <= valid_nxt;
      o_data      <= data_nxt;
      o_overrun   <= overrun_nxt;
    end
  end

  // One counter serves as warm-up timer and sample divider; it restarts on every state change.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == S_RUN) begin
      cnt <= (cnt == DIV_LAST) ? '0 : cnt + 1'b1;
    end else if (state == S_WARMUP) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      prev     <= '0;
      prev_vld <= 1'b0;
      rep_cnt  <= '0;
    end else if (state_nxt != S_RUN) begin
      prev_vld <= 1'b0;
      rep_cnt  <= '0;
    end else if (capture) begin
      prev     <= i_src_rnd;
      prev_vld <= 1'b1;
      rep_cnt  <= rep_nxt;
    end
  end

endmodule

// File: doc/trng_seq_ctrl.md
Name: trng_seq_ctrl

Overview:
- Sequencer for the free-running LFSR entropy source array.
- Holds the source in reset while idle, then enables it and waits out a warm-up period.
- Decimates the sampled source word and runs a repetition-count health test on each capture.
- Delivers accepted words over a valid/ready stream; sits between the entropy source and the conditioner/consumer.

Parameters:
- RNG_WIDTH, 32, width of the source sample and output word.
- WARMUP_CYCLES, 16, cycles the source runs enabled before the first capture (>=1).
- SAMPLE_DIV, 4, RUN-state cycles between captures (>=1).
- REP_LIMIT, 3, consecutive identical captures that declare failure (>=2).
- CNT_W, 8, width of the warm-up and divider counters; must hold max(WARMUP_CYCLES, SAMPLE_DIV).

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_start  in  1  level/pulse; starts generation from IDLE.
- i_stop  in  1  returns to IDLE from any state except FAIL.
- i_clear_fail  in  1  clears FAIL, returns to IDLE.
- o_src_reset  out  1  drives the entropy source i_reset.
- o_src_en  out  1  drives the entropy source i_en.
- i_src_rnd  in  RNG_WIDTH  registered sample from the entropy source.
- o_data  out  RNG_WIDTH  output word.
- o_valid  out  1  o_data valid.
- i_ready  in  1  consumer accepts o_data.
- o_busy  out  1  state is WARMUP or RUN.
- o_fail  out  1  sticky health-test failure.
- o_overrun  out  1  one-cycle pulse: capture dropped because the output was full.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-low on i_reset_n.
- All outputs are registered.
- Reset values: state IDLE, o_src_reset=1, o_src_en=0, o_data=0, o_valid=0, o_busy=0, o_fail=0, o_overrun=0; all counters 0; prev-valid flag 0.
- IDLE: o_src_reset=1, o_src_en=0.
  - i_start && !i_stop -> WARMUP. If both are high, stop wins and the state stays IDLE.
- WARMUP: o_src_reset=0, o_src_en=1, o_busy=1. Counter runs for exactly WARMUP_CYCLES cycles, then -> RUN with the divider at 0.
- RUN: o_src_en=1, o_busy=1. Divider counts 0..SAMPLE_DIV-1 and wraps. A capture happens on the cycle the divider equals SAMPLE_DIV-1.
- Capture health test:
  - If prev-valid and i_src_rnd == prev, increment rep_cnt; otherwise rep_cnt=1.
  - prev <= i_src_rnd, prev-valid <= 1.
  - If the new rep_cnt reaches REP_LIMIT -> FAIL. The failing word is never presented.
- Capture delivery (test passed):
  - If !o_valid, or o_valid && i_ready in the same cycle: o_data <= i_src_rnd, o_valid <= 1 on the next cycle.
  - Otherwise the word is dropped, o_overrun pulses for 1 cycle, and o_data stays unchanged.
- Handshake:
  - Transfer occurs on o_valid && i_ready.
  - o_valid drops the next cycle unless a simultaneous capture reloads it.
  - o_data is stable while o_valid && !i_ready.
- i_stop in WARMUP or RUN -> IDLE next cycle.
  - o_valid is cleared and any pending word is discarded.
  - prev-valid and rep_cnt are cleared.
  - A capture coinciding with i_stop is ignored.
- FAIL: o_src_reset=1, o_src_en=0, o_fail=1, o_valid=0, o_busy=0.
  - i_start and i_stop are ignored.
  - i_clear_fail -> IDLE, with o_fail cleared the next cycle.
- Health state does not persist across restarts: prev-valid is cleared on every entry to WARMUP.
- Reset mid-operation returns every register to its reset value on the next edge, regardless of state.
- Counter wrap: the divider resets to 0 on every capture. Counters never overflow by construction of CNT_W.

Test Plan:
All scenarios use WARMUP_CYCLES=16, SAMPLE_DIV=4, REP_LIMIT=3.
1. Basic start: reset, then i_start at cycle 0 with i_ready=1.
   -> o_src_reset=0 and o_src_en=1 from cycle 1; o_busy=1.
   -> First o_valid at cycle 21 carrying i_src_rnd from cycle 20; subsequent valids every 4 cycles.
2. Backpressure: i_ready=0 after the first word.
   -> o_data holds its value.
   -> o_overrun pulses at each later capture (cycles 24, 28, ...).
   -> Raising i_ready at cycle 30 transfers the held word; the next capture at cycle 32 is delivered.
3. Repetition failure: i_src_rnd held at 32'hA5A5A5A5.
   -> Captures at cycles 20 and 24 are delivered; capture at cycle 28 sets o_fail=1 at cycle 29, with o_src_en=0 and o_src_reset=1.
   -> i_start then has no effect; i_clear_fail returns to IDLE with o_fail=0.
4. Near-repeat: captures alternate 1,1,2,2,1.
   -> No failure; all five words are delivered.
5. Stop mid-run: i_stop in the same cycle as a capture, with o_valid=1 and i_ready=0.
   -> Next cycle: IDLE, o_valid=0, o_src_en=0, o_src_reset=1, no o_overrun.
   -> i_start && i_stop together in IDLE keeps the state in IDLE.
6. Reset mid-WARMUP: i_reset_n=0 at cycle 8.
   -> All outputs return to reset values at the next edge.
   -> A fresh i_start yields the first o_valid 21 cycles later.
